// File: rtl/ram_1r1w_pipe.sv
// Simple-dual-port RAM with partition masks, a configurable-latency read pipeline,
// optional same-cycle write forwarding and a post-reset clear sequencer.
module ram_1r1w_pipe #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SIZE           = 1024,
  parameter int unsigned NUM_PARTITIONS = 4,
  parameter int unsigned ADDR_WIDTH     = $clog2(SIZE),
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned BYPASS         = 1,
  parameter int unsigned CLEAR_ON_RESET = 1,
  parameter string       INIT_FILE      = ""
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic                      wr_en,
  input  logic [NUM_PARTITIONS-1:0] wr_mask,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  input  logic                      rd_en,
  input  logic [NUM_PARTITIONS-1:0] rd_mask,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_valid,
  output logic                      ready
);

  localparam int unsigned PartWidth = DATA_WIDTH / NUM_PARTITIONS;
  localparam bit          DoClear   = (CLEAR_ON_RESET != 0) && (INIT_FILE == "");

  if (DATA_WIDTH % NUM_PARTITIONS != 0) begin : g_badPartition
    $fatal(1, "ram_1r1w_pipe: DATA_WIDTH must be divisible by NUM_PARTITIONS");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_badLatency
    $fatal(1, "ram_1r1w_pipe: RD_LATENCY must be in 1..4");
  end

  logic [DATA_WIDTH-1:0] mem [SIZE];

  // Addresses can only fall outside the array when SIZE is not a power of two.
  logic wrInRange, rdInRange;
  if (SIZE == (1 << ADDR_WIDTH)) begin : g_pow2
    assign wrInRange = 1'b1;
    assign rdInRange = 1'b1;
  end else begin : g_npow2
    assign wrInRange = (32'(wr_addr) < SIZE);
    assign rdInRange = (32'(rd_addr) < SIZE);
  end

  typedef enum logic [1:0] {RESET, CLEAR, READY} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clrAddr_q, clrAddr_d;
  logic                  clrWe;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RESET;
      clrAddr_q <= '0;
    end else begin
      state_q   <= state_d;
      clrAddr_q <= clrAddr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clrAddr_d = clrAddr_q;
    clrWe     = 1'b0;
    case (state_q)
      RESET: begin
        clrAddr_d = '0;
        state_d   = DoClear ? CLEAR : READY;
      end
      CLEAR: begin
        clrWe     = 1'b1;
        clrAddr_d = clrAddr_q + 1'b1;
        if (clrAddr_q == ADDR_WIDTH'(SIZE - 1)) begin
          clrAddr_d = '0;
          state_d   = READY;
        end
      end
      READY:   state_d = READY;
      default: state_d = RESET;
    endcase
  end

  assign ready = (state_q == READY);

  logic userWe, rdFire;
  assign userWe = ready && !rst && wr_en && wrInRange;
  assign rdFire = ready && !rst && rd_en;

  logic [DATA_WIDTH-1:0] wrMaskBits, rdMaskBits;
  always_comb begin
    wrMaskBits = '0;
    rdMaskBits = '0;
    for (int j = 0; j < NUM_PARTITIONS; j++) begin
      wrMaskBits[j*PartWidth +: PartWidth] = {PartWidth{wr_mask[j]}};
      rdMaskBits[j*PartWidth +: PartWidth] = {PartWidth{rd_mask[j]}};
    end
  end

  // The clear sequencer and user writes never overlap, so they share one port.
  logic                      memWe;
  logic [ADDR_WIDTH-1:0]     memWAddr;
  logic [DATA_WIDTH-1:0]     memWData;
  logic [NUM_PARTITIONS-1:0] memWMask;
  always_comb begin
    memWe    = userWe;
    memWAddr = wr_addr;
    memWData = wr_data;
    memWMask = wr_mask;
    if (clrWe) begin
      memWe    = 1'b1;
      memWAddr = clrAddr_q;
      memWData = '0;
      memWMask = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int j = 0; j < NUM_PARTITIONS; j++) begin
        if (memWMask[j]) begin
          mem[memWAddr][j*PartWidth +: PartWidth] <= memWData[j*PartWidth +: PartWidth];
        end
      end
    end
  end

  logic                  collide;
  logic [DATA_WIDTH-1:0] oldWord, mergedWord, rdWord;
  always_comb begin
    collide    = (BYPASS != 0) && userWe && (wr_addr == rd_addr);
    oldWord    = rdInRange ? mem[rd_addr] : '0;
    mergedWord = collide ? ((oldWord & ~wrMaskBits) | (wr_data & wrMaskBits)) : oldWord;
    rdWord     = mergedWord & rdMaskBits;
  end

  // Data stages only advance behind a valid, so the last stage holds between reads.
  logic [RD_LATENCY-1:0] rdValid_q;
  logic [DATA_WIDTH-1:0] rdData_q [RD_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      rdValid_q <= '0;
      for (int k = 0; k < RD_LATENCY; k++) begin
        rdData_q[k] <= '0;
      end
    end else begin
      rdValid_q[0] <= rdFire;
      if (rdFire) begin
        rdData_q[0] <= rdWord;
      end
      for (int k = 1; k < RD_LATENCY; k++) begin
        rdValid_q[k] <= rdValid_q[k-1];
        if (rdValid_q[k-1]) begin
          rdData_q[k] <= rdData_q[k-1];
        end
      end
    end
  end

  assign rd_valid = rdValid_q[RD_LATENCY-1];
  assign rd_data  = rdData_q[RD_LATENCY-1];

endmodule

// File: tb/tb_ram_1r1w_pipe.sv
// Self-checking bench for ram_1r1w_pipe: a forwarding and a non-forwarding instance
// share stimulus and are compared against a word-array reference model.
module tb_ram_1r1w_pipe;

  localparam int DW  = 32;
  localparam int SZ  = 16;
  localparam int NP  = 4;
  localparam int AW  = 4;
  localparam int PW  = DW / NP;
  localparam int LAT = 2;

  logic          clk;
  logic          rst;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic [NP-1:0] wr_mask;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [NP-1:0] rd_mask;
  logic [DW-1:0] rd_data_b, rd_data_n;
  logic          rd_valid_b, rd_valid_n, ready_b, ready_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ram_1r1w_pipe #(.DATA_WIDTH(DW), .SIZE(SZ), .NUM_PARTITIONS(NP), .RD_LATENCY(LAT),
                  .BYPASS(1), .CLEAR_ON_RESET(1)) dutByp (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
    .wr_mask(wr_mask), .rd_addr(rd_addr), .rd_en(rd_en), .rd_mask(rd_mask),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .ready(ready_b));

  ram_1r1w_pipe #(.DATA_WIDTH(DW), .SIZE(SZ), .NUM_PARTITIONS(NP), .RD_LATENCY(LAT),
                  .BYPASS(0), .CLEAR_ON_RESET(1)) dutNoByp (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
    .wr_mask(wr_mask), .rd_addr(rd_addr), .rd_en(rd_en), .rd_mask(rd_mask),
    .rd_data(rd_data_n), .rd_valid(rd_valid_n), .ready(ready_n));

  typedef struct {
    bit            we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [NP-1:0] wm;
    bit            re;
    logic [AW-1:0] ra;
    logic [NP-1:0] rm;
  } stim_t;

  typedef struct {
    int            due;
    logic [DW-1:0] vByp;
    logic [DW-1:0] vNoByp;
  } rdItem_t;

  logic [DW-1:0] mdl [SZ];
  rdItem_t       pend[$];
  int            cyc;
  int            clrLeft;
  bit            mdlReady;
  logic          expValid;
  logic [DW-1:0] expB, expN;
  int            nTests, nFail;

  function automatic logic [DW-1:0] expand(input logic [NP-1:0] m);
    logic [DW-1:0] r = '0;
    for (int j = 0; j < NP; j++) if (m[j]) r[j*PW +: PW] = '1;
    return r;
  endfunction

  function automatic stim_t mk(input bit we, input int wa, input logic [DW-1:0] wd,
                               input logic [NP-1:0] wm, input bit re, input int ra,
                               input logic [NP-1:0] rm);
    stim_t s;
    s.we = we; s.wa = AW'(wa); s.wd = wd; s.wm = wm;
    s.re = re; s.ra = AW'(ra); s.rm = rm;
    return s;
  endfunction

  function automatic stim_t idleStim();
    return mk(1'b0, 0, '0, '0, 1'b0, 0, '0);
  endfunction

  task automatic applyStimulus(input stim_t s);
    wr_en = s.we; wr_addr = s.wa; wr_data = s.wd; wr_mask = s.wm;
    rd_en = s.re; rd_addr = s.ra; rd_mask = s.rm;
  endtask

  // Model: reset zeroes the whole array and arms a countdown to ready (one cycle
  // leaving reset plus one per word). Reads are queued with the cycle on which
  // their result becomes visible after the clock edge.
  task automatic tick();
    bit            rstAtEdge;
    logic [DW-1:0] oldW, newW;
    rdItem_t       it;
    rstAtEdge = rst;
    if (rstAtEdge) begin
      mdlReady = 1'b0;
      clrLeft  = SZ + 1;
      pend.delete();
      for (int a = 0; a < SZ; a++) mdl[a] = '0;
    end else if (!mdlReady) begin
      clrLeft--;
      if (clrLeft == 0) mdlReady = 1'b1;
    end else begin
      if (rd_en) begin
        oldW = mdl[rd_addr];
        newW = oldW;
        if (wr_en && wr_addr == rd_addr)
          newW = (oldW & ~expand(wr_mask)) | (wr_data & expand(wr_mask));
        it.due    = cyc + LAT;
        it.vByp   = newW & expand(rd_mask);
        it.vNoByp = oldW & expand(rd_mask);
        pend.push_back(it);
      end
      if (wr_en)
        mdl[wr_addr] = (mdl[wr_addr] & ~expand(wr_mask)) | (wr_data & expand(wr_mask));
    end
    @(posedge clk);
    cyc++;
    #1;
    if (rstAtEdge) begin
      expValid = 1'b0; expB = '0; expN = '0;
    end else if (pend.size() > 0 && pend[0].due == cyc) begin
      it = pend.pop_front();
      expValid = 1'b1; expB = it.vByp; expN = it.vNoByp;
    end else begin
      expValid = 1'b0;
    end
  endtask

  task automatic test_reset();
    int            waitCycles;
    logic [DW-1:0] gotB[$];
    stim_t         s;
    applyStimulus(idleStim());
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      nTests++;
      if (ready_b !== 1'b0 || ready_n !== 1'b0 || rd_valid_b !== 1'b0 || rd_data_b !== '0) begin
        nFail++;
        $display("[TB] FAIL reset_hold: ready=%b/%b valid=%b data=%h, want 0/0 0 00000000",
                 ready_b, ready_n, rd_valid_b, rd_data_b);
      end
    end
    rst = 1'b0;
    waitCycles = 0;
    tick();
    while (ready_b !== 1'b1 && waitCycles < 100) begin
      waitCycles++;
      tick();
    end
    nTests++;
    if (waitCycles != SZ || ready_n !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL ready_delay: ready low for %0d cycles (other ready=%b), want %0d", waitCycles, ready_n, SZ);
    end
    for (int i = 0; i < SZ + LAT; i++) begin
      s = (i < SZ) ? mk(1'b0, 0, '0, '0, 1'b1, i, 4'hF) : idleStim();
      applyStimulus(s);
      tick();
      nTests++;
      if (rd_valid_b !== expValid || rd_data_b !== expB || rd_valid_n !== expValid || rd_data_n !== expN) begin
        nFail++;
        $display("[TB] FAIL clear_read step %0d: valid=%b/%b data=%h/%h, want valid=%b data=%h/%h",
                 i, rd_valid_b, rd_valid_n, rd_data_b, rd_data_n, expValid, expB, expN);
      end
      if (rd_valid_b === 1'b1) gotB.push_back(rd_data_b);
    end
    nTests++;
    if (gotB.size() != SZ || gotB.or() !== '0) begin
      nFail++;
      $display("[TB] FAIL clear_contents: %0d reads returned %p, want %0d zero words", gotB.size(), gotB, SZ);
    end
  endtask

  task automatic test_masked_write();
    stim_t         seq[$];
    logic [DW-1:0] gotB[$], gotN[$];
    seq.push_back(mk(1'b1, 5, 32'hAABBCCDD, 4'b1111, 1'b0, 0, '0));
    seq.push_back(mk(1'b1, 5, 32'h11223344, 4'b0101, 1'b0, 0, '0));
    seq.push_back(mk(1'b0, 0, '0, '0, 1'b1, 5, 4'b1111));
    seq.push_back(mk(1'b0, 0, '0, '0, 1'b1, 5, 4'b0011));
    seq.push_back(idleStim());
    seq.push_back(idleStim());
    foreach (seq[i]) begin
      applyStimulus(seq[i]);
      tick();
      nTests++;
      if (rd_valid_b !== expValid || rd_data_b !== expB || rd_valid_n !== expValid || rd_data_n !== expN) begin
        nFail++;
        $display("[TB] FAIL masked step %0d: valid=%b/%b data=%h/%h, want valid=%b data=%h/%h",
                 i, rd_valid_b, rd_valid_n, rd_data_b, rd_data_n, expValid, expB, expN);
      end
      if (rd_valid_b === 1'b1) gotB.push_back(rd_data_b);
      if (rd_valid_n === 1'b1) gotN.push_back(rd_data_n);
    end
    nTests++;
    if (gotB.size() != 2 || gotB[0] !== 32'hAA22CC44 || gotB[1] !== 32'h0000CC44 ||
        gotN.size() != 2 || gotN[0] !== 32'hAA22CC44 || gotN[1] !== 32'h0000CC44) begin
      nFail++;
      $display("[TB] FAIL masked_values: got %p / %p, want AA22CC44 0000CC44", gotB, gotN);
    end
  endtask

  task automatic test_back_to_back();
    stim_t         seq[$];
    logic [DW-1:0] gotB[$];
    int            vSteps[$];
    int            firstRd;
    for (int a = 1; a <= 4; a++) seq.push_back(mk(1'b1, a, DW'(a), 4'hF, 1'b0, 0, '0));
    firstRd = seq.size();
    for (int a = 1; a <= 4; a++) seq.push_back(mk(1'b0, 0, '0, '0, 1'b1, a, 4'hF));
    repeat (4) seq.push_back(idleStim());
    foreach (seq[i]) begin
      applyStimulus(seq[i]);
      tick();
      nTests++;
      if (rd_valid_b !== expValid || rd_data_b !== expB || rd_valid_n !== expValid || rd_data_n !== expN) begin
        nFail++;
        $display("[TB] FAIL b2b step %0d: valid=%b/%b data=%h/%h, want valid=%b data=%h/%h",
                 i, rd_valid_b, rd_valid_n, rd_data_b, rd_data_n, expValid, expB, expN);
      end
      if (rd_valid_b === 1'b1) begin
        gotB.push_back(rd_data_b);
        vSteps.push_back(i);
      end
    end
    for (int k = 0; k < 4; k++) begin
      nTests++;
      if (k >= gotB.size() || vSteps[k] != firstRd + LAT - 1 + k || gotB[k] !== DW'(k + 1)) begin
        nFail++;
        $display("[TB] FAIL b2b_seq %0d: steps %p data %p, want step %0d data %0d",
                 k, vSteps, gotB, firstRd + LAT - 1 + k, k + 1);
      end
    end
    nTests++;
    if (gotB.size() != 4) begin
      nFail++;
      $display("[TB] FAIL b2b_count: %0d valid cycles, want 4", gotB.size());
    end
  endtask

  task automatic test_collision();
    stim_t         seq[$];
    logic [DW-1:0] gotB[$], gotN[$];
    seq.push_back(mk(1'b1, 7, '0, 4'hF, 1'b0, 0, '0));
    seq.push_back(idleStim());
    seq.push_back(mk(1'b1, 7, 32'hDEADBEEF, 4'b1100, 1'b1, 7, 4'b1111));
    seq.push_back(mk(1'b0, 0, '0, '0, 1'b1, 7, 4'b1111));
    repeat (3) seq.push_back(idleStim());
    foreach (seq[i]) begin
      applyStimulus(seq[i]);
      tick();
      nTests++;
      if (rd_valid_b !== expValid || rd_data_b !== expB || rd_valid_n !== expValid || rd_data_n !== expN) begin
        nFail++;
        $display("[TB] FAIL collision step %0d: valid=%b/%b data=%h/%h, want valid=%b data=%h/%h",
                 i, rd_valid_b, rd_valid_n, rd_data_b, rd_data_n, expValid, expB, expN);
      end
      if (rd_valid_b === 1'b1) gotB.push_back(rd_data_b);
      if (rd_valid_n === 1'b1) gotN.push_back(rd_data_n);
    end
    nTests++;
    if (gotB.size() != 2 || gotB[0] !== 32'hDEAD0000 || gotB[1] !== 32'hDEAD0000) begin
      nFail++;
      $display("[TB] FAIL collision_bypass: got %p, want DEAD0000 DEAD0000", gotB);
    end
    nTests++;
    if (gotN.size() != 2 || gotN[0] !== 32'h00000000 || gotN[1] !== 32'hDEAD0000) begin
      nFail++;
      $display("[TB] FAIL collision_nobypass: got %p, want 00000000 DEAD0000", gotN);
    end
  endtask

  task automatic test_concurrent();
    stim_t         seq[$];
    logic [DW-1:0] gotB[$], gotN[$];
    seq.push_back(mk(1'b1, 9, 32'h99, 4'hF, 1'b0, 0, '0));
    seq.push_back(mk(1'b1, 2, 32'h55, 4'hF, 1'b1, 9, 4'hF));
    seq.push_back(mk(1'b0, 0, '0, '0, 1'b1, 2, 4'hF));
    repeat (3) seq.push_back(idleStim());
    foreach (seq[i]) begin
      applyStimulus(seq[i]);
      tick();
      nTests++;
      if (rd_valid_b !== expValid || rd_data_b !== expB || rd_valid_n !== expValid || rd_data_n !== expN) begin
        nFail++;
        $display("[TB] FAIL concurrent step %0d: valid=%b/%b data=%h/%h, want valid=%b data=%h/%h",
                 i, rd_valid_b, rd_valid_n, rd_data_b, rd_data_n, expValid, expB, expN);
      end
      if (rd_valid_b === 1'b1) gotB.push_back(rd_data_b);
      if (rd_valid_n === 1'b1) gotN.push_back(rd_data_n);
    end
    nTests++;
    if (gotB.size() != 2 || gotB[0] !== 32'h99 || gotB[1] !== 32'h55 ||
        gotN.size() != 2 || gotN[0] !== 32'h99 || gotN[1] !== 32'h55) begin
      nFail++;
      $display("[TB] FAIL concurrent_values: got %p / %p, want 00000099 00000055", gotB, gotN);
    end
  endtask

  task automatic test_random();
    stim_t s;
    for (int i = 0; i < 400; i++) begin
      s.we = ($urandom_range(0, 1) == 1);
      s.wa = AW'($urandom_range(0, SZ - 1));
      s.wd = $urandom;
      s.wm = NP'($urandom);
      s.re = ($urandom_range(0, 3) != 0);
      s.ra = ($urandom_range(0, 3) == 0) ? s.wa : AW'($urandom_range(0, SZ - 1));
      s.rm = NP'($urandom);
      applyStimulus(s);
      tick();
      nTests++;
      if (rd_valid_b !== expValid || rd_data_b !== expB || rd_valid_n !== expValid ||
          rd_data_n !== expN || ready_b !== mdlReady) begin
        nFail++;
        $display("[TB] FAIL random cycle %0d: valid=%b/%b data=%h/%h ready=%b, want valid=%b data=%h/%h ready=%b",
                 i, rd_valid_b, rd_valid_n, rd_data_b, rd_data_n, ready_b, expValid, expB, expN, mdlReady);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int            waitCycles;
    logic [DW-1:0] gotB[$];
    stim_t         s;
    for (int a = 0; a < SZ; a++) begin
      applyStimulus(mk(1'b1, a, 32'hFFFFFFFF, 4'hF, 1'b0, 0, '0));
      tick();
    end
    applyStimulus(idleStim());
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    waitCycles = 0;
    tick();
    while (ready_b !== 1'b1 && waitCycles < 100) begin
      waitCycles++;
      tick();
    end
    nTests++;
    if (waitCycles != SZ) begin
      nFail++;
      $display("[TB] FAIL midclear_delay: ready low for %0d cycles, want %0d", waitCycles, SZ);
    end
    for (int i = 0; i < SZ + LAT; i++) begin
      s = (i < SZ) ? mk(1'b0, 0, '0, '0, 1'b1, i, 4'hF) : idleStim();
      applyStimulus(s);
      tick();
      nTests++;
      if (rd_valid_b !== expValid || rd_data_b !== expB || rd_valid_n !== expValid || rd_data_n !== expN) begin
        nFail++;
        $display("[TB] FAIL midclear_read step %0d: valid=%b/%b data=%h/%h, want valid=%b data=%h/%h",
                 i, rd_valid_b, rd_valid_n, rd_data_b, rd_data_n, expValid, expB, expN);
      end
      if (rd_valid_b === 1'b1) gotB.push_back(rd_data_b);
    end
    nTests++;
    if (gotB.size() != SZ || gotB.or() !== '0) begin
      nFail++;
      $display("[TB] FAIL midclear_contents: %0d reads returned %p, want %0d zero words", gotB.size(), gotB, SZ);
    end
  endtask

  task automatic test_reset_inflight();
    stim_t seq[$];
    int    validSeen;
    seq.push_back(mk(1'b1, 3, 32'hA5A5A5A5, 4'hF, 1'b0, 0, '0));
    seq.push_back(mk(1'b0, 0, '0, '0, 1'b1, 3, 4'hF));
    seq.push_back(idleStim());
    seq.push_back(idleStim());
    seq.push_back(mk(1'b0, 0, '0, '0, 1'b1, 3, 4'hF));
    foreach (seq[i]) begin
      applyStimulus(seq[i]);
      tick();
      nTests++;
      if (rd_valid_b !== expValid || rd_data_b !== expB || rd_valid_n !== expValid || rd_data_n !== expN) begin
        nFail++;
        $display("[TB] FAIL inflight_setup step %0d: valid=%b/%b data=%h/%h, want valid=%b data=%h/%h",
                 i, rd_valid_b, rd_valid_n, rd_data_b, rd_data_n, expValid, expB, expN);
      end
    end
    // Second read issued on the reset edge while the first is still in the pipeline.
    applyStimulus(mk(1'b0, 0, '0, '0, 1'b1, 4, 4'hF));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(idleStim());
    validSeen = 0;
    for (int i = 0; i < 6; i++) begin
      if (rd_valid_b === 1'b1 || rd_valid_n === 1'b1) validSeen++;
      nTests++;
      if (rd_data_b !== '0 || rd_data_n !== '0 || rd_valid_b !== expValid || rd_data_b !== expB) begin
        nFail++;
        $display("[TB] FAIL inflight_flush cycle %0d: valid=%b/%b data=%h/%h, want valid=0 data=00000000",
                 i, rd_valid_b, rd_valid_n, rd_data_b, rd_data_n);
      end
      tick();
    end
    nTests++;
    if (validSeen != 0) begin
      nFail++;
      $display("[TB] FAIL inflight_valid: %0d valid strobes after reset, want 0", validSeen);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    nTests = 0; nFail = 0; cyc = 0; clrLeft = 0; mdlReady = 1'b0;
    expValid = 1'b0; expB = '0; expN = '0;
    rst = 1'b1;
    applyStimulus(idleStim());
    test_reset();
    test_masked_write();
    test_back_to_back();
    test_collision();
    test_concurrent();
    test_random();
    test_reset_mid_clear();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
